zrb_spi_master: RTL and testbench
=================================

ZRB_SPI_MASTER -- requirements
Module: zrb_spi_master

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, frame length in bits (>=2).
REQ-002 SHALL have parameter CPOL, default 0, sck idle level.
REQ-003 SHALL have parameter CPHA, default 0, sampling phase (0: sample on leading edge; 1: sample on trailing edge).
REQ-004 SHALL have parameter CLK_DIV, default 4, sck half-period in clk cycles (>=2).
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, transfer request sampled on rising clk.
REQ-008 SHALL have port data_in, input, NUM_BITS, word to transmit.
REQ-009 SHALL have port data_out, output, NUM_BITS, last received word.
REQ-010 SHALL have port busy, output, 1, transfer or cs guard time in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-012 SHALL have ports sck, cs, spi_out as 1-bit outputs and spi_in as a 1-bit input; these are the serial clock, active-low select, MOSI and MISO.

Function
REQ-013 SHALL use an FSM with states IDLE, SETUP, SHIFT, HOLD and GUARD.
REQ-014 In IDLE with start=1 (cycle 0), SHALL latch data_in into the tx shift register, enter SETUP, and drive cs=0 and busy=1 from cycle 1.
REQ-015 SHALL ignore start in any state other than IDLE; no queuing.
REQ-016 SHALL produce sck edge k (k=1..2*NUM_BITS) at cycle 1+CLK_DIV*k. Odd k are leading edges and even k are trailing edges.
REQ-017 SHALL transmit MSB first.
REQ-018 With CPHA=0, SHALL present the MSB on spi_out from cycle 1, shift on each trailing edge except the last, and sample spi_in on each leading edge.
REQ-019 With CPHA=1, SHALL shift spi_out on each leading edge (first leading edge presents the MSB) and sample spi_in on each trailing edge.
REQ-020 SHALL sample spi_in directly with no synchroniser, and sample it in the same clk cycle as the sck edge.
REQ-021 SHALL enter HOLD after edge 2*NUM_BITS, drive cs=1 at cycle 1+CLK_DIV*(2*NUM_BITS+1), and pulse done for that single cycle.
REQ-022 SHALL update data_out with the received word in the same cycle that done pulses, and hold it until the next done.
REQ-023 SHALL hold busy=1 through GUARD for CLK_DIV cycles, so busy=0 at cycle 1+CLK_DIV*(2*NUM_BITS+2) and start becomes acceptable in that cycle.
REQ-024 SHALL ignore start asserted on the cycle done pulses.
REQ-025 SHALL hold sck=CPOL whenever cs=1.
REQ-026 SHALL count half-periods with a counter of width clogb2(CLK_DIV) and bits with a counter of width clogb2(2*NUM_BITS+1); neither counter shall free-run outside SETUP, SHIFT and HOLD.

Reset
REQ-027 Asserting reset at any time, including mid-frame, SHALL immediately force the following: FSM=IDLE, cs=1, sck=CPOL, spi_out=0, busy=0, done=0, data_out=0, all counters and shift registers to 0.
REQ-028 After reset deasserts, SHALL accept start on the first rising clk edge.

Structure
REQ-029 The FSM state encoding and the clogb2 function SHALL live in the shared package zrb_spi_pkg.
REQ-030 The half-period tick generator SHALL be the sub-module zrb_spi_tick (inputs clk, reset, enable; output tick every CLK_DIV cycles while enable=1; cleared when enable=0).

Verification
REQ-031 Loopback (spi_out to spi_in), defaults, start with data_in=0xA5 at cycle 0 -> cs falls at cycle 1, first sck rise at cycle 5, cs rises and done=1 at cycle 69, data_out=0xA5, busy=0 at cycle 73.
REQ-032 Model slave returning 0x3C, with the slave shifting on falling sck and sampling on rising sck, start with data_in=0xFF -> data_out=0x3C; exactly 8 rising sck edges observed while cs=0.
REQ-033 start held high continuously for 200 cycles with data_in=0x01 -> exactly two frames, second cs fall at cycle 74, cs high for at least 4 cycles between frames.
REQ-034 reset asserted at cycle 30 mid-frame -> same cycle cs=1, sck=0, busy=0, data_out=0; a new start at 0x5A after release completes normally.
REQ-035 All four CPOL/CPHA combinations with loopback and data_in=0x96 -> data_out=0x96, sck idles at CPOL, 16 sck edges per frame.

Source files
------------

// File: rtl/zrb_spi_pkg.sv
// Shared definitions for the zrb SPI master: FSM state encoding and counter sizing.
package zrb_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GUARD
  } spi_state_t;

  // Bits needed to hold any value in 0..value-1 (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (value > (32'd1 << i)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/zrb_spi_tick.sv
// Half-period tick generator: pulses tick every CLK_DIV cycles while enabled.
module zrb_spi_tick
  import zrb_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = clogb2($unsigned(CLK_DIV));

  logic [CW-1:0] cnt;

  always_comb tick = enable && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/zrb_spi_master.sv
// SPI master: one NUM_BITS frame per start, MSB first, configurable CPOL/CPHA,
// followed by a CLK_DIV-cycle chip-select guard time.
module zrb_spi_master
  import zrb_spi_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] data_in,
  output logic [NUM_BITS-1:0] data_out,
  output logic                busy,
  output logic                done,
  output logic                sck,
  output logic                cs,
  output logic                spi_out,
  input  logic                spi_in
);

  localparam int unsigned   EW       = clogb2($unsigned(2 * NUM_BITS + 1));
  localparam logic [EW-1:0] LAST_IDX = EW'(2 * NUM_BITS - 1);

  spi_state_t          state, state_next;
  logic                tick, tick_en, edge_go, leading, last_edge;
  logic                sample_en, shift_en;
  logic [EW-1:0]       edge_cnt;
  logic [NUM_BITS-1:0] tx_sr, rx_sr;

  zrb_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // edge_cnt holds the number of sck edges already produced, so the edge a
  // tick creates is edge_cnt+1: leading when edge_cnt is even.
  always_comb begin
    state_next = state;
    cs         = 1'b1;
    busy       = 1'b1;
    tick_en    = 1'b1;
    edge_go    = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    leading    = ~edge_cnt[0];
    last_edge  = (edge_cnt == LAST_IDX);
    unique case (state)
      IDLE: begin
        busy    = 1'b0;
        tick_en = 1'b0;
        if (start) state_next = SETUP;
      end
      SETUP: begin
        cs      = 1'b0;
        edge_go = tick;
        if (tick) state_next = SHIFT;
      end
      SHIFT: begin
        cs      = 1'b0;
        edge_go = tick;
        if (tick && last_edge) state_next = HOLD;
      end
      HOLD: begin
        cs = 1'b0;
        if (tick) state_next = GUARD;
      end
      GUARD: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (CPHA == 0) begin
      sample_en = edge_go && leading;
      shift_en  = edge_go && !leading && !last_edge;
    end else begin
      sample_en = edge_go && !leading;
      shift_en  = edge_go && leading;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      sck      <= 1'(CPOL);
      spi_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        rx_sr    <= '0;
        edge_cnt <= '0;
        sck      <= 1'(CPOL);
        // CPHA=0 must have the MSB on the line before the first edge.
        if (CPHA == 0) begin
          spi_out <= data_in[NUM_BITS-1];
          tx_sr   <= {data_in[NUM_BITS-2:0], 1'b0};
        end else begin
          tx_sr <= data_in;
        end
      end else begin
        if (edge_go) begin
          sck      <= ~sck;
          edge_cnt <= edge_cnt + 1'b1;
        end
        if (shift_en) begin
          spi_out <= tx_sr[NUM_BITS-1];
          tx_sr   <= {tx_sr[NUM_BITS-2:0], 1'b0};
        end
        if (sample_en) rx_sr <= {rx_sr[NUM_BITS-2:0], spi_in};
        if (state == HOLD && tick) begin
          done     <= 1'b1;
          data_out <= rx_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_zrb_spi_master.sv
// Scoreboard bench for zrb_spi_master: loopback/slave frames, held start,
// mid-frame reset and all four SPI modes.
module tb_zrb_spi_master;

  localparam int NB       = 8;
  localparam int CD       = 4;
  localparam int DONE_REL = 1 + CD * (2 * NB + 1);
  localparam int IDLE_REL = 1 + CD * (2 * NB + 2);

  typedef struct {
    logic [7:0] rx_exp;
    logic [7:0] tx;
    int         c0;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       busy, done, sck, cs, mosi, miso;
  logic       use_slave = 1'b0;
  logic [7:0] slave_word = '0, slave_sr = '0, slave_rx = '0;

  logic       start_m = 1'b0;
  logic [7:0] data_m = '0;
  logic [3:0] m_busy, m_done, m_sck, m_cs, m_mosi;
  logic [7:0] m_dout [4];

  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  exp_t q[$];
  exp_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zrb_spi_master #(.NUM_BITS(NB), .CPOL(0), .CPHA(0), .CLK_DIV(CD)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .sck(sck), .cs(cs), .spi_out(mosi), .spi_in(miso)
  );

  for (genvar g = 0; g < 4; g++) begin : gm
    zrb_spi_master #(.NUM_BITS(NB), .CPOL(g / 2), .CPHA(g % 2), .CLK_DIV(CD)) u_m (
      .clk(clk), .reset(rst_n), .start(start_m), .data_in(data_m), .data_out(m_dout[g]),
      .busy(m_busy[g]), .done(m_done[g]), .sck(m_sck[g]), .cs(m_cs[g]),
      .spi_out(m_mosi[g]), .spi_in(m_mosi[g])
    );
  end

  // Mode-0 slave: shifts on falling sck, samples MOSI on rising sck.
  assign miso = use_slave ? slave_sr[7] : mosi;
  always @(negedge cs) begin
    slave_sr = slave_word;
    slave_rx = '0;
  end
  always @(negedge sck) if (!cs) slave_sr = {slave_sr[6:0], 1'b0};
  always @(posedge sck) if (!cs) slave_rx = {slave_rx[6:0], mosi};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Main-DUT monitor
  exp_t cur;
  int   nedges = 0, nrise = 0, rise_cyc = 0, last_c0 = 0, done_cnt = 0;
  bit   had_rise = 0, tim_ok = 1;
  logic p_cs = 1'b1, p_sck = 1'b0, p_busy = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      had_rise = 0;
    end else begin
      if (p_done) chk("done_one_cycle", int'(done), 0);
      if (p_cs && !cs) begin
        chk("cs_fall_sb_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) cur = q[0];
        chk("cs_fall_cycle", cyc - cur.c0, 1);
        if (had_rise) begin
          n_total++;
          if (cyc - rise_cyc >= CD) n_pass++;
          else $display("FAIL cs_gap: got %0d cycles need >= %0d", cyc - rise_cyc, CD);
        end
        nedges = 0; nrise = 0; tim_ok = 1;
      end
      if (!cs && sck != p_sck) begin
        nedges++;
        if (sck) nrise++;
        if (cyc - cur.c0 != 1 + CD * nedges) tim_ok = 0;
      end
      if (!p_cs && cs) begin
        rise_cyc = cyc;
        had_rise = 1;
      end
      if (done) begin
        chk("done_sb_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("data_out", int'(data_out), int'(cur.rx_exp));
          chk("done_cycle", cyc - cur.c0, DONE_REL);
          chk("cs_high_at_done", int'(cs), 1);
          chk("sck_idle_at_done", int'(sck), 0);
          chk("sck_edges", nedges, 2 * NB);
          chk("sck_rises", nrise, NB);
          chk("sck_edge_timing", int'(tim_ok), 1);
          chk("mosi_at_slave", int'(slave_rx), int'(cur.tx));
          last_c0 = cur.c0;
          done_cnt++;
        end
      end
      if (p_busy && !busy) chk("busy_fall_cycle", cyc - last_c0, IDLE_REL);
    end
    p_cs = cs; p_sck = sck; p_busy = busy; p_done = done;
  end

  // Mode-instance monitor
  int         m_edges[4];
  bit         idle_bad[4];
  bit         m_any;
  logic [3:0] mp_sck = '0, mp_cs = '1;

  always @(negedge clk) begin
    if (rst_n) begin
      m_any = 0;
      for (int i = 0; i < 4; i++) begin
        if (mp_cs[i] && !m_cs[i]) m_edges[i] = 0;
        if (!m_cs[i] && m_sck[i] != mp_sck[i]) m_edges[i]++;
        if (m_cs[i] && int'(m_sck[i]) != i / 2) idle_bad[i] = 1;
        if (m_done[i]) begin
          m_any = 1;
          chk("mode_sb_nonempty", int'(mq.size() > 0), 1);
          if (mq.size() > 0) begin
            chk("mode_data_out", int'(m_dout[i]), int'(mq[0].rx_exp));
            chk("mode_done_cycle", cyc - mq[0].c0, DONE_REL);
          end
          chk("mode_sck_edges", m_edges[i], 2 * NB);
          chk("mode_sck_idle", int'(idle_bad[i]), 0);
          idle_bad[i] = 0;
        end
      end
      if (m_any && mq.size() > 0) mq.delete(0);
    end
    mp_sck = m_sck; mp_cs = m_cs;
  end

  task automatic send(input logic [7:0] d, input bit slv, input logic [7:0] sw);
    exp_t e;
    use_slave  = slv;
    slave_word = sw;
    data_in    = d;
    start      = 1'b1;
    e.rx_exp   = slv ? sw : d;
    e.tx       = d;
    e.c0       = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_idle_m();
    int n = 0;
    while (m_busy != 4'b0000 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("mode_idle_timeout", int'(m_busy), 0);
  endtask

  logic [7:0] d, s;
  int         base, c0r, dc0, nwait;
  exp_t       em;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", int'(cs), 1);
    chk("rst_sck", int'(sck), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_mode_sck", int'(m_sck), 12);
    chk("rst_mode_cs", int'(m_cs), 15);
    rst_n = 1'b1;

    // Loopback 0xA5, with a stray start mid-frame that must be ignored.
    send(8'hA5, 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    data_in = 8'h00;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      send(d, (i % 2) == 1, s);
      wait_idle();
    end

    send(8'hFF, 1'b1, 8'h3C);
    wait_idle();

    // Start held high for 200 cycles: accepted whenever the master is idle.
    base      = cyc;
    use_slave = 1'b0;
    data_in   = 8'h01;
    start     = 1'b1;
    for (int k = 0; k * IDLE_REL < 200; k++) begin
      em.rx_exp = 8'h01;
      em.tx     = 8'h01;
      em.c0     = base + k * IDLE_REL;
      q.push_back(em);
    end
    dc0 = done_cnt;
    repeat (200) @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_frames_in_window", done_cnt - dc0, 2);
    wait_idle();

    // Reset at cycle 30 of a frame.
    c0r = cyc;
    send(8'($urandom_range(1, 255)), 1'b0, 8'h00);
    repeat (29) @(posedge clk);
    #1;
    chk("pre_reset_cycle", cyc - c0r, 30);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_data_out", int'(data_out), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", int'(cs), 1);
    chk("midrst_sck", int'(sck), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_mosi", int'(mosi), 0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h5A, 1'b0, 8'h00);
    wait_idle();

    // All four CPOL/CPHA modes in loopback.
    wait_idle_m();
    for (int i = 0; i < 3; i++) begin
      d         = (i == 0) ? 8'h96 : 8'($urandom_range(0, 255));
      em.rx_exp = d;
      em.tx     = d;
      em.c0     = cyc;
      mq.push_back(em);
      data_m  = d;
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      wait_idle_m();
    end

    nwait = 0;
    while ((q.size() > 0 || mq.size() > 0) && nwait < 500) begin
      @(posedge clk);
      nwait++;
    end
    chk("main_sb_drained", q.size(), 0);
    chk("mode_sb_drained", mq.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
